// File: rtl/run_sequencer.sv
// run_sequencer
//   Host-side run controller for the 9-bit basic processor core. One run:
//   stream a byte block into core data memory, pulse Start, wait for Ack
//   (bounded by MAX_CYCLES), then stream a result block back out of memory.
//
// Ports
//   Clk, Reset        clock, synchronous active-high reset
//   Go                run request (sampled only while idle)
//   LoadBase/LoadLen  load window (len 0 skips the load)
//   DumpBase/DumpLen  dump window (len 0 skips the dump)
//   InValid/InData/InReady    input byte stream
//   OutValid/OutData/OutReady result byte stream
//   MemSel/MemWrEn/MemAddr/MemWrData/MemRdData  data-memory port
//   Start/Ack         core handshake
//   Busy/Done/Error/CycleCount  status

module run_sequencer #(
  parameter int          START_CYC  = 2,
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Go,
  input  logic [7:0]  LoadBase,
  input  logic [7:0]  LoadLen,
  input  logic [7:0]  DumpBase,
  input  logic [7:0]  DumpLen,
  input  logic        InValid,
  input  logic [7:0]  InData,
  output logic        InReady,
  output logic        OutValid,
  output logic [7:0]  OutData,
  input  logic        OutReady,
  output logic        MemSel,
  output logic        MemWrEn,
  output logic [7:0]  MemAddr,
  output logic [7:0]  MemWrData,
  input  logic [7:0]  MemRdData,
  output logic        Start,
  input  logic        Ack,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [15:0] CycleCount
);

  localparam int SCW = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DUMP, DONE} state_t;

  state_t         state, state_nx;
  logic [7:0]     load_base, load_len, dump_base, dump_len;
  logic [7:0]     idx;
  logic [15:0]    run_cnt;
  logic [SCW-1:0] st_cnt;
  logic           error_q;

  // Registered output flags, decoded from the next state so they change
  // on the same edge as the state register.
  logic in_ready_q, out_valid_q, mem_sel_q, start_q, busy_q, done_q;

  logic        load_hs, dump_hs, load_last, dump_last, st_last;
  logic [15:0] run_inc;
  logic        timeout;

  // in_ready_q / out_valid_q are exactly "state is LOAD / DUMP".
  assign load_hs   = in_ready_q & InValid;
  assign dump_hs   = out_valid_q & OutReady;
  assign load_last = (idx == 8'(load_len - 8'd1));
  assign dump_last = (idx == 8'(dump_len - 8'd1));
  assign st_last   = (st_cnt == SCW'(START_CYC - 1));

  // Saturating run counter; timeout is judged on the value this cycle
  // will leave behind, so MAX_CYCLES RUN cycles elapse before it fires.
  assign run_inc = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;
  assign timeout = (run_inc >= MAX_CYCLES);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (Go) state_nx = (LoadLen != 8'd0) ? LOAD : START;
      LOAD:  if (load_hs && load_last) state_nx = START;
      START: if (st_last) state_nx = RUN;
      RUN:   if (Ack || timeout) state_nx = (dump_len != 8'd0) ? DUMP : DONE;
      DUMP:  if (dump_hs && dump_last) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      load_base   <= '0;
      load_len    <= '0;
      dump_base   <= '0;
      dump_len    <= '0;
      idx         <= '0;
      run_cnt     <= '0;
      st_cnt      <= '0;
      error_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mem_sel_q   <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      in_ready_q  <= (state_nx == LOAD);
      out_valid_q <= (state_nx == DUMP);
      mem_sel_q   <= (state_nx == LOAD) || (state_nx == DUMP);
      start_q     <= (state_nx == START);
      busy_q      <= (state_nx != IDLE);
      done_q      <= (state_nx == DONE);

      case (state)
        IDLE: if (Go) begin
          load_base <= LoadBase;
          load_len  <= LoadLen;
          dump_base <= DumpBase;
          dump_len  <= DumpLen;
          idx       <= '0;
          run_cnt   <= '0;
          st_cnt    <= '0;
          error_q   <= 1'b0;
        end
        // idx is shared: cleared at the end of the load so the dump
        // starts from offset 0.
        LOAD: if (load_hs) idx <= load_last ? 8'd0 : idx + 8'd1;
        START: st_cnt <= st_cnt + SCW'(1);
        RUN: begin
          run_cnt <= run_inc;
          // Ack in the timeout cycle wins: no error.
          if (!Ack && timeout) error_q <= 1'b1;
        end
        DUMP: if (dump_hs) idx <= idx + 8'd1;
        default: ;
      endcase
    end
  end

  assign InReady    = in_ready_q;
  assign OutValid   = out_valid_q;
  assign OutData    = MemRdData;
  assign MemSel     = mem_sel_q;
  assign MemWrEn    = in_ready_q & InValid;
  assign MemAddr    = in_ready_q  ? 8'(load_base + idx) :
                      out_valid_q ? 8'(dump_base + idx) : 8'd0;
  assign MemWrData  = in_ready_q ? InData : 8'd0;
  assign Start      = start_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Error      = error_q;
  assign CycleCount = run_cnt;

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

  localparam int START_CYC = 2;
  localparam int MAXC      = 20;
  localparam int NEVER     = 100000;

  logic        Clk, Reset, Go;
  logic [7:0]  LoadBase, LoadLen, DumpBase, DumpLen;
  logic        InValid, InReady, OutValid, OutReady;
  logic [7:0]  InData, OutData;
  logic        MemSel, MemWrEn;
  logic [7:0]  MemAddr, MemWrData, MemRdData;
  logic        Start, Ack, Busy, Done, Error;
  logic [15:0] CycleCount;

  int checks = 0;
  int errors = 0;

  run_sequencer #(.START_CYC(START_CYC), .MAX_CYCLES(16'(MAXC))) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go),
    .LoadBase(LoadBase), .LoadLen(LoadLen), .DumpBase(DumpBase), .DumpLen(DumpLen),
    .InValid(InValid), .InData(InData), .InReady(InReady),
    .OutValid(OutValid), .OutData(OutData), .OutReady(OutReady),
    .MemSel(MemSel), .MemWrEn(MemWrEn), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .MemRdData(MemRdData),
    .Start(Start), .Ack(Ack), .Busy(Busy), .Done(Done), .Error(Error),
    .CycleCount(CycleCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Data memory: synchronous write, combinational read.
  logic [7:0] mem [0:255];
  always @(posedge Clk) if (MemWrEn) mem[MemAddr] <= MemWrData;
  assign MemRdData = mem[MemAddr];

  // Core model: Ack rises in the ack_delay-th cycle after Start falls.
  // ack_delay 0 = Ack constantly high.
  int ack_delay = 0;
  int run_k = 0;
  always @(negedge Clk) begin
    if (ack_delay == 0) Ack = 1'b1;
    else if (Start) begin run_k = 0; Ack = 1'b0; end
    else if (Busy) begin run_k = run_k + 1; Ack = (run_k >= ack_delay); end
    else Ack = 1'b0;
  end

  logic [7:0] ref_mem    [0:255];
  logic [7:0] load_bytes [0:255];
  int st_first_wr, st_last_wr, st_cycles;

  // One complete run, checked against the expected memory image and
  // stream contents. vmode/rmode: 0 = always, 1 = alternating, 2 = random.
  task automatic do_run(input logic [7:0] lb, ll, db, dl, input int ack_d,
                        input int vmode, rmode, input bit go_hold,
                        input bit exp_err, input int exp_cc);
    int li = 0, oi = 0, n = 0, n_start = 0, n_inr = 0, n_ov = 0;
    bit stall = 0, seen_done = 0;
    logic [7:0] pa = 0, pd = 0, e;
    for (int i = 0; i < ll; i++) ref_mem[8'(lb + i)] = load_bytes[i];
    st_first_wr = -1; st_last_wr = -1;
    ack_delay = ack_d;
    @(negedge Clk);
    Go = 1'b1; LoadBase = lb; LoadLen = ll; DumpBase = db; DumpLen = dl;
    InValid = 1'b0; OutReady = 1'b0;
    while (!seen_done && n < 3000) begin
      @(negedge Clk);
      n++;
      Go = go_hold;
      LoadBase = 8'($urandom); LoadLen = 8'($urandom);
      DumpBase = 8'($urandom); DumpLen = 8'($urandom);
      InValid  = (vmode == 0) ? 1'b1 : (vmode == 1) ? (n % 2 == 1) : 1'($urandom);
      InData   = (li < ll) ? load_bytes[li] : 8'($urandom);
      OutReady = (rmode == 0) ? 1'b1 : (rmode == 1) ? (n % 2 == 0) : 1'($urandom);
      #1;
      if (n == 1) begin
        checks++;
        if (Busy !== 1'b1 || Error !== 1'b0 || CycleCount !== 16'd0) begin
          errors++;
          $display("FAIL go_accept busy=%b err=%b cc=%0d required busy=1 err=0 cc=0", Busy, Error, CycleCount);
        end
      end
      checks++;
      if (MemWrEn !== (InValid && InReady)) begin
        errors++; $display("FAIL wren_qual n=%0d wren=%b required %b", n, MemWrEn, InValid && InReady);
      end
      if (MemWrEn) begin
        checks++;
        if (li >= ll) begin
          errors++; $display("FAIL extra_write addr=%h required no write", MemAddr);
        end else if (MemAddr !== 8'(lb + li) || MemWrData !== load_bytes[li] || MemSel !== 1'b1) begin
          errors++;
          $display("FAIL load_write i=%0d addr=%h data=%h sel=%b required addr=%h data=%h sel=1",
                   li, MemAddr, MemWrData, MemSel, 8'(lb + li), load_bytes[li]);
        end
        if (st_first_wr < 0) st_first_wr = n;
        st_last_wr = n;
        li++;
      end
      if (InReady) n_inr++;
      if (Start) n_start++;
      if (OutValid) begin
        n_ov++;
        checks++;
        if (stall && (MemAddr !== pa || OutData !== pd)) begin
          errors++; $display("FAIL stall_stable addr=%h data=%h required addr=%h data=%h", MemAddr, OutData, pa, pd);
        end
        checks++;
        if (MemAddr !== 8'(db + oi) || MemSel !== 1'b1 || MemWrEn !== 1'b0) begin
          errors++; $display("FAIL dump_addr i=%0d addr=%h sel=%b required addr=%h sel=1", oi, MemAddr, MemSel, 8'(db + oi));
        end
        if (OutReady) begin
          e = ref_mem[8'(db + oi)];
          checks++;
          if (OutData !== e) begin
            errors++; $display("FAIL dump_data i=%0d got=%h required=%h", oi, OutData, e);
          end
          oi++;
        end
      end
      stall = OutValid && !OutReady; pa = MemAddr; pd = OutData;
      if (Done) seen_done = 1;
    end
    st_cycles = n;
    checks++;
    if (!seen_done) begin
      errors++; $display("FAIL run_timeout no Done within %0d cycles", n);
    end
    checks++;
    if (li != ll || oi != dl) begin
      errors++; $display("FAIL counts writes=%0d outs=%0d required writes=%0d outs=%0d", li, oi, ll, dl);
    end
    checks++;
    if (n_start != START_CYC) begin
      errors++; $display("FAIL start_len got=%0d required=%0d", n_start, START_CYC);
    end
    checks++;
    if ((ll == 0 && n_inr != 0) || (dl == 0 && n_ov != 0)) begin
      errors++; $display("FAIL zero_len inready_cycles=%0d outvalid_cycles=%0d required 0", n_inr, n_ov);
    end
    checks++;
    if (Error !== exp_err || CycleCount !== 16'(exp_cc) || Busy !== 1'b1) begin
      errors++;
      $display("FAIL done_status err=%b cc=%0d busy=%b required err=%b cc=%0d busy=1",
               Error, CycleCount, Busy, exp_err, exp_cc);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge Clk); Go = 1'b0; InValid = 1'b0; OutReady = 1'b0; #1;
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0 || Error !== exp_err || CycleCount !== 16'(exp_cc)) begin
        errors++;
        $display("FAIL after_done k=%0d done=%b busy=%b err=%b cc=%0d required done=0 busy=0 err=%b cc=%0d",
                 k, Done, Busy, Error, CycleCount, exp_err, exp_cc);
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Go = 1'b0; InValid = 1'b1; InData = 8'hA5; OutReady = 1'b1;
    LoadBase = 8'h10; LoadLen = 8'h4; DumpBase = 0; DumpLen = 0;
    repeat (2) @(negedge Clk);
    #1;
    checks++;
    if ({InReady, OutValid, MemSel, MemWrEn, MemAddr, MemWrData, Start, Busy, Done, Error, CycleCount} !== '0) begin
      errors++;
      $display("FAIL reset_vals rdy=%b ov=%b sel=%b we=%b addr=%h wd=%h st=%b busy=%b done=%b err=%b cc=%0d required all 0",
               InReady, OutValid, MemSel, MemWrEn, MemAddr, MemWrData, Start, Busy, Done, Error, CycleCount);
    end
    checks++;
    if (OutData !== MemRdData) begin
      errors++; $display("FAIL reset_outdata got=%h required=%h", OutData, MemRdData);
    end
    @(negedge Clk); Reset = 1'b0; InValid = 1'b0;
  endtask

  task automatic test_basic;
    load_bytes[0] = 8'h11; load_bytes[1] = 8'h22; load_bytes[2] = 8'h33; load_bytes[3] = 8'h44;
    do_run(8'h00, 8'd4, 8'h00, 8'd4, 10, 0, 0, 0, 0, 10);
    checks++;
    if (st_first_wr != 1 || st_last_wr != 4) begin
      errors++; $display("FAIL load_timing first=%0d last=%0d required first=1 last=4", st_first_wr, st_last_wr);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 6; i++) load_bytes[i] = 8'($urandom);
    do_run(8'h40, 8'd6, 8'h40, 8'd6, 3, 1, 1, 0, 0, 3);
    for (int i = 0; i < 9; i++) load_bytes[i] = 8'($urandom);
    do_run(8'h60, 8'd9, 8'h62, 8'd7, 5, 2, 2, 0, 0, 5);
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 4; i++) load_bytes[i] = 8'($urandom);
    do_run(8'hFE, 8'd4, 8'hFE, 8'd4, 2, 0, 0, 0, 0, 2);
    for (int i = 0; i < 32; i++) load_bytes[i] = 8'($urandom);
    do_run(8'hF0, 8'd32, 8'hF0, 8'd32, 4, 2, 2, 0, 0, 4);
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 3; i++) load_bytes[i] = 8'($urandom);
    do_run(8'h80, 8'd3, 8'h80, 8'd3, NEVER, 0, 0, 0, 1, MAXC);
    // Ack in the very cycle the counter reaches the limit: Ack wins.
    do_run(8'h80, 8'd3, 8'h80, 8'd3, MAXC, 0, 0, 0, 0, MAXC);
    do_run(8'h80, 8'd0, 8'h80, 8'd2, MAXC + 1, 0, 2, 0, 1, MAXC);
    // Next run clears Error on Go.
    do_run(8'h80, 8'd0, 8'h80, 8'd0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_zero_and_ignored_go;
    do_run(8'h00, 8'd0, 8'h00, 8'd0, 0, 0, 0, 1, 0, 1);
    checks++;
    if (st_cycles != START_CYC + 2) begin
      errors++; $display("FAIL min_run cycles=%0d required=%0d", st_cycles, START_CYC + 2);
    end
    for (int i = 0; i < 2; i++) load_bytes[i] = 8'($urandom);
    do_run(8'h20, 8'd2, 8'h20, 8'd2, 6, 0, 0, 1, 0, 6);
  endtask

  task automatic test_reset_mid_load;
    int acc = 0;
    for (int i = 0; i < 4; i++) load_bytes[i] = 8'($urandom);
    @(negedge Clk);
    Go = 1'b1; LoadBase = 8'h30; LoadLen = 8'd4; DumpBase = 8'h30; DumpLen = 8'd4;
    for (int k = 0; k < 10 && acc < 2; k++) begin
      @(negedge Clk); Go = 1'b0; InValid = 1'b1; InData = load_bytes[acc]; #1;
      if (MemWrEn) acc++;
    end
    @(negedge Clk); Reset = 1'b1; InValid = 1'b1; OutReady = 1'b1;
    @(negedge Clk); #1;
    checks++;
    if ({InReady, OutValid, MemSel, MemWrEn, MemAddr, MemWrData, Start, Busy, Done, Error, CycleCount} !== '0) begin
      errors++;
      $display("FAIL midload_reset rdy=%b ov=%b sel=%b we=%b addr=%h wd=%h st=%b busy=%b done=%b err=%b cc=%0d required all 0",
               InReady, OutValid, MemSel, MemWrEn, MemAddr, MemWrData, Start, Busy, Done, Error, CycleCount);
    end
    @(negedge Clk); Reset = 1'b0; InValid = 1'b0;
    for (int i = 0; i < 4; i++) load_bytes[i] = 8'($urandom);
    do_run(8'h30, 8'd4, 8'h30, 8'd4, 7, 0, 0, 0, 0, 7);
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      logic [7:0] lb, ll, off, dl;
      int ad;
      lb  = 8'($urandom);
      ll  = 8'($urandom_range(1, 24));
      off = 8'($urandom_range(0, ll - 1));
      dl  = 8'($urandom_range(0, ll - off));
      ad  = $urandom_range(1, 25);
      for (int i = 0; i < ll; i++) load_bytes[i] = 8'($urandom);
      do_run(lb, ll, 8'(lb + off), dl, ad, 2, 2, 0, ad >= MAXC + 1, (ad >= MAXC + 1) ? MAXC : ad);
    end
  endtask

  initial begin
    Reset = 1'b1; Go = 1'b0; InValid = 1'b0; InData = 0; OutReady = 1'b0;
    LoadBase = 0; LoadLen = 0; DumpBase = 0; DumpLen = 0;
    test_reset;
    test_basic;
    test_backpressure;
    test_wrap;
    test_timeout;
    test_zero_and_ignored_go;
    test_reset_mid_load;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
